// File: rtl/cv32e40p_offload_pkg.sv
// Shared types and constants for the C-interface offload adapter.
// The struct types describe the default 32-bit configuration.
package cv32e40p_offload_pkg;

   localparam int unsigned DEPTH_DEFAULT  = 4;
   localparam int unsigned RD_W           = 5;
   localparam int unsigned DATA_W_DEFAULT = 32;
   localparam int unsigned HART_W_DEFAULT = 32;

   typedef struct packed {
      logic [RD_W-1:0]           rd;
      logic [HART_W_DEFAULT-1:0] hart_id;
   } meta_t;

   typedef struct packed {
      logic [DATA_W_DEFAULT-1:0] data;
      logic                      err;
   } resp_t;

endpackage

// File: rtl/cv32e40p_offload_fifo.sv
// Synchronous FIFO with simultaneous push/pop and an occupancy count.
// DEPTH=1 degenerates to a single-entry register.
module cv32e40p_offload_fifo
   import cv32e40p_offload_pkg::*;
#(
   parameter type         T     = logic [31:0],
   parameter int unsigned DEPTH = DEPTH_DEFAULT,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  T                 data_i,
   input  logic             pop_i,
   output T                 data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] cnt_o
);

   // Storage is rounded up to a power of two so the pointer always indexes in range.
   T                 mem_q [2**PTR_W];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      cnt_d    = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign cnt_o   = cnt_q;

endmodule

// File: rtl/cv32e40p_offload_adapter.sv
// C-interface offload adapter: issues to an in-order accelerator, returns results in order.
// Optional C_OFFLOAD_BYPASS_EN forwards a result straight to the response port when the result FIFO is empty.
module cv32e40p_offload_adapter
   import cv32e40p_offload_pkg::*;
#(
   parameter int unsigned DEPTH  = DEPTH_DEFAULT,
   parameter int unsigned NUM_RS = 3,
   parameter int unsigned DATA_W = DATA_W_DEFAULT,
   parameter int unsigned HART_W = HART_W_DEFAULT
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     c_q_valid_i,
   output logic                     c_p_ready_o,
   input  logic [NUM_RS*DATA_W-1:0] c_q_rs_i,
   input  logic [31:0]              c_q_instr_data_i,
   input  logic [RD_W-1:0]          c_q_addr_i,
   input  logic [HART_W-1:0]        c_q_hart_id_i,
   output logic                     c_p_valid_o,
   input  logic                     c_q_ready_i,
   output logic [DATA_W-1:0]        c_p_data_o,
   output logic                     c_p_error_o,
   output logic                     c_p_dualwb_o,
   output logic [HART_W-1:0]        c_p_hart_id_o,
   output logic [RD_W-1:0]          c_p_rd_o,
   output logic                     acc_req_o,
   input  logic                     acc_gnt_i,
   output logic [NUM_RS*DATA_W-1:0] acc_operands_o,
   output logic [31:0]              acc_instr_o,
   input  logic                     acc_rvalid_i,
   input  logic [DATA_W-1:0]        acc_rdata_i,
   input  logic                     acc_rerr_i
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   // Local struct widths follow this instance's parameters.
   typedef struct packed {
      logic [RD_W-1:0]   rd;
      logic [HART_W-1:0] hart_id;
   } meta_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              err;
   } resp_t;

   logic             space, issue, retire, rvalid_ok, byp;
   logic             res_push, res_pop;
   logic             meta_full, meta_empty, res_full, res_empty;
   logic [CNT_W-1:0] count, res_cnt;
   meta_t            meta_in, meta_head;
   resp_t            res_in, res_head, resp_head;

   // The meta FIFO occupancy is the outstanding-operation count.
   assign space       = (count < CNT_W'(DEPTH));
   assign acc_req_o   = c_q_valid_i & space;
   assign c_p_ready_o = acc_gnt_i & space;
   assign issue       = c_q_valid_i & c_p_ready_o;

   assign acc_operands_o = c_q_rs_i;
   assign acc_instr_o    = c_q_instr_data_i;

   // A result with no pending operation is dropped.
   assign rvalid_ok = acc_rvalid_i & (res_cnt < count);

`ifdef C_OFFLOAD_BYPASS_EN
   assign byp = rvalid_ok & res_empty;
`else
   assign byp = 1'b0;
`endif

   assign res_in    = '{data: acc_rdata_i, err: acc_rerr_i};
   assign meta_in   = '{rd: c_q_addr_i, hart_id: c_q_hart_id_i};
   assign resp_head = byp ? res_in : res_head;

   assign c_p_valid_o = ~res_empty | byp;
   assign retire      = c_p_valid_o & c_q_ready_i;
   assign res_push    = rvalid_ok & ~(byp & c_q_ready_i);
   assign res_pop     = retire & ~res_empty;

   always_comb begin
      c_p_data_o    = '0;
      c_p_error_o   = 1'b0;
      c_p_rd_o      = '0;
      c_p_hart_id_o = '0;
      c_p_dualwb_o  = 1'b0;
      if (c_p_valid_o) begin
         c_p_data_o    = resp_head.data;
         c_p_error_o   = resp_head.err;
         c_p_rd_o      = meta_head.rd;
         c_p_hart_id_o = meta_head.hart_id;
      end
   end

   cv32e40p_offload_fifo #(.T(meta_t), .DEPTH(DEPTH)) u_meta_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (issue),
      .data_i  (meta_in),
      .pop_i   (retire),
      .data_o  (meta_head),
      .full_o  (meta_full),
      .empty_o (meta_empty),
      .cnt_o   (count)
   );

   cv32e40p_offload_fifo #(.T(resp_t), .DEPTH(DEPTH)) u_res_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (res_push),
      .data_i  (res_in),
      .pop_i   (res_pop),
      .data_o  (res_head),
      .full_o  (res_full),
      .empty_o (res_empty),
      .cnt_o   (res_cnt)
   );

   a_rvalid_pending: assert property (@(posedge clk_i) disable iff (rst_i)
      acc_rvalid_i |-> (res_cnt < count));
   a_issue_room: assert property (@(posedge clk_i) disable iff (rst_i)
      issue |-> ~meta_full);
   a_res_room: assert property (@(posedge clk_i) disable iff (rst_i)
      res_push |-> ~res_full);
   a_retire_meta: assert property (@(posedge clk_i) disable iff (rst_i)
      retire |-> ~meta_empty);

endmodule

// File: tb/tb_cv32e40p_offload_adapter.sv
// Directed self-checking bench for cv32e40p_offload_adapter (DEPTH=4).
// Bypass-specific checks compile only when C_OFFLOAD_BYPASS_EN is defined.
module tb_cv32e40p_offload_adapter;

   localparam int DEPTH  = 4;
   localparam int NUM_RS = 3;
   localparam int DATA_W = 32;
   localparam int HART_W = 32;

   logic                     clk_i = 1'b0;
   logic                     rst_i = 1'b0;
   logic                     c_q_valid_i = 1'b0;
   logic                     c_p_ready_o;
   logic [NUM_RS*DATA_W-1:0] c_q_rs_i = '0;
   logic [31:0]              c_q_instr_data_i = '0;
   logic [4:0]               c_q_addr_i = '0;
   logic [HART_W-1:0]        c_q_hart_id_i = '0;
   logic                     c_p_valid_o;
   logic                     c_q_ready_i = 1'b0;
   logic [DATA_W-1:0]        c_p_data_o;
   logic                     c_p_error_o;
   logic                     c_p_dualwb_o;
   logic [HART_W-1:0]        c_p_hart_id_o;
   logic [4:0]               c_p_rd_o;
   logic                     acc_req_o;
   logic                     acc_gnt_i = 1'b1;
   logic [NUM_RS*DATA_W-1:0] acc_operands_o;
   logic [31:0]              acc_instr_o;
   logic                     acc_rvalid_i = 1'b0;
   logic [DATA_W-1:0]        acc_rdata_i = '0;
   logic                     acc_rerr_i = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   cv32e40p_offload_adapter #(
      .DEPTH(DEPTH), .NUM_RS(NUM_RS), .DATA_W(DATA_W), .HART_W(HART_W)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .c_q_valid_i(c_q_valid_i), .c_p_ready_o(c_p_ready_o),
      .c_q_rs_i(c_q_rs_i), .c_q_instr_data_i(c_q_instr_data_i),
      .c_q_addr_i(c_q_addr_i), .c_q_hart_id_i(c_q_hart_id_i),
      .c_p_valid_o(c_p_valid_o), .c_q_ready_i(c_q_ready_i),
      .c_p_data_o(c_p_data_o), .c_p_error_o(c_p_error_o),
      .c_p_dualwb_o(c_p_dualwb_o), .c_p_hart_id_o(c_p_hart_id_o),
      .c_p_rd_o(c_p_rd_o), .acc_req_o(acc_req_o), .acc_gnt_i(acc_gnt_i),
      .acc_operands_o(acc_operands_o), .acc_instr_o(acc_instr_o),
      .acc_rvalid_i(acc_rvalid_i), .acc_rdata_i(acc_rdata_i),
      .acc_rerr_i(acc_rerr_i)
   );

   // Advance to just after the next rising edge; inputs are driven here.
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      cyc();
      cyc();
      rst_i = 1'b0;
      #1;
      total++; if (c_p_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", c_p_valid_o); end
      total++; if (c_p_ready_o !== acc_gnt_i) begin bad++; $display("FAIL reset_ready got=%0b exp=%0b", c_p_ready_o, acc_gnt_i); end
      total++; if (dut.count !== 0) begin bad++; $display("FAIL reset_count got=%0d exp=0", dut.count); end
      total++; if ({c_p_data_o, c_p_rd_o, c_p_hart_id_o, c_p_error_o, c_p_dualwb_o} !== '0) begin
         bad++; $display("FAIL reset_outputs data=%h rd=%0d hart=%h err=%0b dwb=%0b exp=all zero",
                         c_p_data_o, c_p_rd_o, c_p_hart_id_o, c_p_error_o, c_p_dualwb_o); end
   endtask

   task automatic test_single();
      cyc();
      c_q_valid_i = 1'b1; c_q_addr_i = 5'd5; c_q_hart_id_i = '0;
      c_q_rs_i = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
      c_q_instr_data_i = 32'h0020_8053;
      #1;
      total++; if (acc_req_o !== 1'b1) begin bad++; $display("FAIL single_req got=%0b exp=1", acc_req_o); end
      total++; if (acc_operands_o !== {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}) begin
         bad++; $display("FAIL single_operands got=%h", acc_operands_o); end
      total++; if (acc_instr_o !== 32'h0020_8053) begin bad++; $display("FAIL single_instr got=%h exp=00208053", acc_instr_o); end
      cyc();
      c_q_valid_i = 1'b0;
      cyc();
      acc_rvalid_i = 1'b1; acc_rdata_i = 32'h3F80_0000; acc_rerr_i = 1'b0;
      #1;
`ifndef C_OFFLOAD_BYPASS_EN
      total++; if (c_p_valid_o !== 1'b0) begin bad++; $display("FAIL single_latency got=%0b exp=0", c_p_valid_o); end
`endif
      cyc();
      acc_rvalid_i = 1'b0;
      #1;
      total++; if (c_p_valid_o !== 1'b1 || c_p_data_o !== 32'h3F80_0000 || c_p_rd_o !== 5'd5 || c_p_error_o !== 1'b0) begin
         bad++; $display("FAIL single_resp v=%0b data=%h rd=%0d err=%0b exp v=1 data=3f800000 rd=5 err=0",
                         c_p_valid_o, c_p_data_o, c_p_rd_o, c_p_error_o); end
      cyc();
      total++; if (c_p_valid_o !== 1'b1 || c_p_data_o !== 32'h3F80_0000 || c_p_rd_o !== 5'd5) begin
         bad++; $display("FAIL single_hold v=%0b data=%h rd=%0d exp v=1 data=3f800000 rd=5", c_p_valid_o, c_p_data_o, c_p_rd_o); end
      c_q_ready_i = 1'b1;
      cyc();
      c_q_ready_i = 1'b0;
      #1;
      total++; if (c_p_valid_o !== 1'b0 || dut.count !== 0) begin
         bad++; $display("FAIL single_retire v=%0b count=%0d exp v=0 count=0", c_p_valid_o, dut.count); end
   endtask

   task automatic test_backpressure();
      for (int i = 1; i <= 5; i++) begin
         cyc();
         c_q_valid_i = 1'b1; c_q_addr_i = 5'(i); c_q_hart_id_i = 32'(i);
         #1;
         if (i == 5) begin
            total++; if (c_p_ready_o !== 1'b0 || acc_req_o !== 1'b0) begin
               bad++; $display("FAIL bp_blocked ready=%0b req=%0b exp 0 0", c_p_ready_o, acc_req_o); end
         end
      end
      for (int i = 1; i <= 4; i++) begin
         cyc();
         acc_rvalid_i = 1'b1; acc_rdata_i = 32'h100 + 32'(i); acc_rerr_i = 1'b0;
      end
      cyc();
      acc_rvalid_i = 1'b0; c_q_ready_i = 1'b1;
      #1;
      total++; if (dut.count !== 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", dut.count); end
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) begin
            cyc();
            if (k == 3) c_q_valid_i = 1'b0;
            #1;
         end
         total++; if (c_p_valid_o !== 1'b1 || c_p_rd_o !== 5'(k) || c_p_data_o !== 32'h100 + 32'(k) || c_p_hart_id_o !== 32'(k)) begin
            bad++; $display("FAIL bp_order k=%0d v=%0b rd=%0d data=%h hart=%0d exp rd=%0d data=%h",
                            k, c_p_valid_o, c_p_rd_o, c_p_data_o, c_p_hart_id_o, k, 32'h100 + 32'(k)); end
         if (k == 1) begin
            total++; if (c_p_ready_o !== 1'b0) begin bad++; $display("FAIL bp_same_cycle_credit got=%0b exp=0", c_p_ready_o); end
         end
         if (k == 2) begin
            total++; if (c_p_ready_o !== 1'b1) begin bad++; $display("FAIL bp_fifth_issue got=%0b exp=1", c_p_ready_o); end
         end
      end
      cyc();
      total++; if (c_p_valid_o !== 1'b0 || dut.count !== 1) begin
         bad++; $display("FAIL bp_drain v=%0b count=%0d exp v=0 count=1", c_p_valid_o, dut.count); end
      acc_rvalid_i = 1'b1; acc_rdata_i = 32'h105;
      cyc();
      acc_rvalid_i = 1'b0;
      #1;
      total++; if (c_p_valid_o !== 1'b1 || c_p_rd_o !== 5'd5 || c_p_data_o !== 32'h105) begin
         bad++; $display("FAIL bp_fifth_resp v=%0b rd=%0d data=%h exp v=1 rd=5 data=105", c_p_valid_o, c_p_rd_o, c_p_data_o); end
      cyc();
      c_q_ready_i = 1'b0;
      total++; if (dut.count !== 0) begin bad++; $display("FAIL bp_final_count got=%0d exp=0", dut.count); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         cyc();
         c_q_valid_i = 1'b1; c_q_addr_i = 5'(10 + i); c_q_hart_id_i = 32'hA0 + 32'(i);
      end
      cyc();
      c_q_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         acc_rvalid_i = 1'b1; acc_rdata_i = 32'hA + 32'(i); acc_rerr_i = (i == 1);
         cyc();
      end
      acc_rvalid_i = 1'b0; acc_rerr_i = 1'b0;
      c_q_ready_i = 1'b1; c_q_valid_i = 1'b1; c_q_addr_i = 5'd13; c_q_hart_id_i = 32'hA3;
      #1;
      total++; if (dut.count !== 3 || c_p_ready_o !== 1'b1 || c_p_rd_o !== 5'd10 || c_p_error_o !== 1'b0 || c_p_data_o !== 32'hA) begin
         bad++; $display("FAIL b2b_op1 count=%0d ready=%0b rd=%0d err=%0b data=%h exp 3 1 10 0 a",
                         dut.count, c_p_ready_o, c_p_rd_o, c_p_error_o, c_p_data_o); end
      cyc();
      c_q_valid_i = 1'b0;
      #1;
      total++; if (dut.count !== 3 || c_p_rd_o !== 5'd11 || c_p_error_o !== 1'b1 || c_p_data_o !== 32'hB) begin
         bad++; $display("FAIL b2b_op2 count=%0d rd=%0d err=%0b data=%h exp 3 11 1 b",
                         dut.count, c_p_rd_o, c_p_error_o, c_p_data_o); end
      cyc();
      total++; if (dut.count !== 2 || c_p_rd_o !== 5'd12 || c_p_error_o !== 1'b0 || c_p_data_o !== 32'hC) begin
         bad++; $display("FAIL b2b_op3 count=%0d rd=%0d err=%0b data=%h exp 2 12 0 c",
                         dut.count, c_p_rd_o, c_p_error_o, c_p_data_o); end
      cyc();
      total++; if (c_p_valid_o !== 1'b0 || dut.count !== 1) begin
         bad++; $display("FAIL b2b_gap v=%0b count=%0d exp 0 1", c_p_valid_o, dut.count); end
      acc_rvalid_i = 1'b1; acc_rdata_i = 32'hD;
      cyc();
      acc_rvalid_i = 1'b0;
      #1;
      total++; if (c_p_valid_o !== 1'b1 || c_p_rd_o !== 5'd13 || c_p_hart_id_o !== 32'hA3 || c_p_error_o !== 1'b0) begin
         bad++; $display("FAIL b2b_op4 v=%0b rd=%0d hart=%h err=%0b exp 1 13 a3 0",
                         c_p_valid_o, c_p_rd_o, c_p_hart_id_o, c_p_error_o); end
      cyc();
      c_q_ready_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         cyc();
         c_q_valid_i = 1'b1; c_q_addr_i = 5'(20 + i);
      end
      cyc();
      c_q_valid_i = 1'b0; acc_rvalid_i = 1'b1; acc_rdata_i = 32'hDEAD;
      cyc();
      acc_rvalid_i = 1'b0; rst_i = 1'b1;
      cyc();
      rst_i = 1'b0;
      #1;
      total++; if (c_p_valid_o !== 1'b0 || dut.count !== 0 || c_p_ready_o !== 1'b1) begin
         bad++; $display("FAIL rstmid_state v=%0b count=%0d ready=%0b exp 0 0 1", c_p_valid_o, dut.count, c_p_ready_o); end
      c_q_valid_i = 1'b1; c_q_addr_i = 5'd7; c_q_hart_id_i = 32'h55;
      cyc();
      c_q_valid_i = 1'b0; acc_rvalid_i = 1'b1; acc_rdata_i = 32'h77;
      cyc();
      acc_rvalid_i = 1'b0;
      #1;
      total++; if (c_p_valid_o !== 1'b1 || c_p_rd_o !== 5'd7 || c_p_hart_id_o !== 32'h55 || c_p_data_o !== 32'h77) begin
         bad++; $display("FAIL rstmid_newop v=%0b rd=%0d hart=%h data=%h exp 1 7 55 77",
                         c_p_valid_o, c_p_rd_o, c_p_hart_id_o, c_p_data_o); end
      c_q_ready_i = 1'b1;
      cyc();
      c_q_ready_i = 1'b0;
   endtask

`ifdef C_OFFLOAD_BYPASS_EN
   task automatic test_bypass();
      cyc();
      c_q_valid_i = 1'b1; c_q_addr_i = 5'd3; c_q_hart_id_i = 32'h9;
      cyc();
      c_q_valid_i = 1'b0; c_q_ready_i = 1'b1;
      acc_rvalid_i = 1'b1; acc_rdata_i = 32'h4000_0000;
      #1;
      total++; if (c_p_valid_o !== 1'b1 || c_p_data_o !== 32'h4000_0000 || c_p_rd_o !== 5'd3) begin
         bad++; $display("FAIL bypass_same_cycle v=%0b data=%h rd=%0d exp 1 40000000 3", c_p_valid_o, c_p_data_o, c_p_rd_o); end
      cyc();
      acc_rvalid_i = 1'b0; c_q_ready_i = 1'b0;
      #1;
      total++; if (c_p_valid_o !== 1'b0 || dut.count !== 0 || dut.u_res_fifo.empty_o !== 1'b1) begin
         bad++; $display("FAIL bypass_empty v=%0b count=%0d empty=%0b exp 0 0 1", c_p_valid_o, dut.count, dut.u_res_fifo.empty_o); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
`ifdef C_OFFLOAD_BYPASS_EN
      test_bypass();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cv32e40p_offload_adapter.md
Name: cv32e40p_offload_adapter

Overview:
Parametrised successor of the single-shot C-interface FPU wrapper. Accepts offloaded instructions on the C-request channel and issues them to an in-order accelerator over a req/gnt port. Tracks up to DEPTH outstanding operations, tagging each with rd and hart_id. Returns results on the C-response channel in issue order, with full backpressure.

Parameters:
DEPTH, 4, max outstanding operations (>=1); sizes the tracking and result FIFOs
NUM_RS, 3, source operands per request
DATA_W, 32, operand/result width
HART_W, 32, hart_id width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
c_q_valid_i  in  1  request valid
c_p_ready_o  out  1  request ready
c_q_rs_i  in  NUM_RS*DATA_W  source operands
c_q_instr_data_i  in  32  instruction word
c_q_addr_i  in  5  destination register rd
c_q_hart_id_i  in  HART_W  hart id
c_p_valid_o  out  1  response valid
c_q_ready_i  in  1  response ready
c_p_data_o  out  DATA_W  result
c_p_error_o  out  1  error flag
c_p_dualwb_o  out  1  dual writeback; always 0
c_p_hart_id_o  out  HART_W  hart id of the response
c_p_rd_o  out  5  rd of the response
acc_req_o  out  1  accelerator request
acc_gnt_i  in  1  accelerator grant
acc_operands_o  out  NUM_RS*DATA_W  forwarded c_q_rs_i
acc_instr_o  out  32  forwarded c_q_instr_data_i
acc_rvalid_i  in  1  result valid (no backpressure, in order)
acc_rdata_i  in  DATA_W  result data
acc_rerr_i  in  1  result error

Behaviour:
- Clock is clk_i. Reset rst_i is synchronous and active-high.
- Reset: count=0; both FIFOs empty; c_p_valid_o=0; c_p_data_o, c_p_rd_o, c_p_hart_id_o, c_p_error_o = 0; c_p_dualwb_o=0.
- Credit: `space = (count < DEPTH)`, using the registered count only.
  - A retire in the same cycle does not free a slot for that cycle.
- Issue path, combinational:
  - acc_req_o = c_q_valid_i & space
  - c_p_ready_o = acc_gnt_i & space
- Issue handshake is c_q_valid_i & c_p_ready_o. On it, {c_q_addr_i, c_q_hart_id_i} is pushed into the meta FIFO.
- acc_rvalid_i: {acc_rdata_i, acc_rerr_i} is pushed into the result FIFO. Credits guarantee the result FIFO is never full when this happens.
- Response:
  - c_p_valid_o = result FIFO not empty.
  - Data and error come from the result FIFO head; rd and hart_id come from the meta FIFO head.
  - Retire on c_p_valid_o & c_q_ready_i; both FIFOs pop.
  - Outputs hold stable while valid & !ready.
- count update per cycle: +1 on issue, -1 on retire, unchanged if both or neither occur. Width is $clog2(DEPTH+1).
- Latency: acc_rvalid_i in cycle N gives c_p_valid_o in cycle N+1. Throughput is 1 per cycle, sustained.
- FIFOs wrap their pointers modulo DEPTH. DEPTH=1 must work (a single-entry register).
- acc_rvalid_i while the result FIFO holds count entries (no operation pending): protocol violation. It is ignored and flagged by an assertion.
- Reset mid-operation: all in-flight state is discarded. The accelerator must be reset in the same cycle.

Optional Feature:
C_OFFLOAD_BYPASS_EN.
- Defined: when the result FIFO is empty and acc_rvalid_i=1:
  - c_p_valid_o=1 in the same cycle, with acc_rdata_i/acc_rerr_i driven combinationally.
  - If c_q_ready_i=1 the result is not stored (zero latency).
  - Otherwise it is pushed as normal.
- Undefined: the registered path only, with 1-cycle latency.

Decomposition:
- Package cv32e40p_offload_pkg:
  - meta_t {rd[4:0], hart_id}
  - resp_t {data, err}
  - DEPTH_DEFAULT constant
- Sub-module cv32e40p_offload_fifo:
  - Parametrised by type/width and DEPTH.
  - Ports: push, pop, full, empty.
  - Instantiated twice: meta and result.

Test Plan:
- Reset with rst_i=1 for 2 cycles, then release -> c_p_valid_o=0, c_p_ready_o=acc_gnt_i, count=0.
- Single op: rd=5, hart=0, gnt=1; acc_rvalid_i=1 with rdata=0x3F800000 two cycles later -> next cycle c_p_valid_o=1, data=0x3F800000, rd=5, error=0.
- DEPTH=4, c_q_ready_i=0: issue 5 back-to-back ops (rd=1..5) -> 5th blocked (c_p_ready_o=0, acc_req_o=0). Then set ready=1 -> responses rd=1,2,3,4 in order; 5th issues the cycle after the first retire.
- Simultaneous issue and retire at count=3 (DEPTH=4) -> count stays 3. Order preserved; acc_rerr_i=1 on op 2 -> c_p_error_o=1 only on op 2.
- Assert rst_i with 3 ops outstanding -> next cycle c_p_valid_o=0, count=0. A new op then completes with the correct rd.
- With C_OFFLOAD_BYPASS_EN, FIFO empty, c_q_ready_i=1, acc_rvalid_i=1 with data 0x40000000 -> c_p_valid_o=1 and data=0x40000000 in the same cycle; FIFO stays empty.
